keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad, debounces one key at a time, and presents it to the calculator control FSM.
//  Outputs readKey (level, high while a debounced key is held) and pressedkey (4-bit calculator code).
//  Sits directly upstream of the control FSM; its outputs wire 1:1 to that FSM's readKey/pressedkey inputs.
// PARAMETERS
//  SCAN_DIV      1000    clocks each row is driven before its columns are sampled (>=2)
//  DEBOUNCE_CNT  500000  consecutive stable clocks required for press and for release (>=1)
//  REPEAT_DELAY  25000000  clocks held before first auto-repeat (KEYPAD_TYPEMATIC_EN only)
//  REPEAT_PERIOD 5000000   clocks between subsequent auto-repeats (KEYPAD_TYPEMATIC_EN only)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-low reset
//  cols        in   4  keypad column lines, active low, externally pulled up, asynchronous
//  rows        out  4  keypad row drive, one-hot active low (exactly one bit 0 at all times)
//  readKey     out  1  high while a debounced key is held
//  pressedkey  out  4  code of the last debounced key; stable while readKey=1 and after release
// BEHAVIOUR
//  Reset (async, reset=0): rows=4'b1110, readKey=0, pressedkey=0, state=SCAN, all counters 0, row index 0.
//  cols pass through a 2-flop synchronizer; all decisions use the synchronized value colsS.
//  Key map [row][col]: r0: 1 2 3 12(+) | r1: 4 5 6 13(-) | r2: 7 8 9 14(*) | r3: 11(AC) 0 10(=) 15(/).
//  FSM states:
//   SCAN: drive row idx for SCAN_DIV clocks; on the last clock of the slot sample colsS.
//     Any bit low -> latch row and lowest-index low column; go to DEBOUNCE; row drive frozen.
//     Otherwise advance idx (3 wraps to 0).
//   DEBOUNCE: count clocks while the latched column stays low.
//     Column high -> counter cleared, return to SCAN at the next row.
//     Counter reaches DEBOUNCE_CNT -> pressedkey<=code, readKey<=1 (same edge), go to PRESSED.
//   PRESSED: row frozen; other columns and rows are ignored.
//     Latched column high -> go to RELEASE, counter cleared.
//   RELEASE: count consecutive clocks with the latched column high.
//     Column low -> return to PRESSED, counter cleared.
//     Reaching DEBOUNCE_CNT -> readKey<=0, go to SCAN, restarting at row 0 with a fresh SCAN_DIV slot.
//  Latency: key stable-low -> readKey=1 is at most 4*SCAN_DIV + 2 + DEBOUNCE_CNT clocks.
//    Release -> readKey=0 is 2 + DEBOUNCE_CNT clocks.
//  Simultaneous keys in one row: lowest column wins. Keys in other rows are unseen while frozen.
//  Bounce inside a debounce window restarts that window; it never produces a glitch on readKey.
//  pressedkey never changes while readKey=1, so downstream may sample it at any readKey level.
//  readKey low time between two presses is >= DEBOUNCE_CNT clocks (>=1 clk needed downstream).
//  Counters are $clog2(max param + 1) bits wide and saturate at their terminal count.
// CONFIGURATION
//  KEYPAD_TYPEMATIC_EN defined: after readKey has been high REPEAT_DELAY clocks in PRESSED,
//    readKey drops for exactly 2 clocks, then rises again with pressedkey unchanged.
//    The drop repeats every REPEAT_PERIOD clocks while the key stays held.
//    Leaving PRESSED clears the repeat counter.
//  KEYPAD_TYPEMATIC_EN undefined: no repeat logic; readKey stays high until release completes.
// STRUCTURE
//  Shared package keypad_pkg holds:
//    key code constants KEY_EQUAL=10, KEY_AC=11, KEY_PLUS=12, KEY_MINUS=13, KEY_MULT=14, KEY_DIV=15;
//    2-bit state encodings SCAN/DEBOUNCE/PRESSED/RELEASE;
//    function keymap(row,col) returning the 4-bit code.
//    The control FSM imports the same key constants.
//  One sub-module: keypad_sync2 (4-bit 2-flop synchronizer, async active-low reset to 4'b1111).
// TESTING (bench params SCAN_DIV=4, DEBOUNCE_CNT=8; keypad model drives the col of the pressed key low when its row is low)
//  1. Reset low mid-PRESSED (readKey=1) -> readKey=0, rows=4'b1110 at once; after release, no spurious press.
//  2. Hold r1c2 clean -> readKey rises within 4*4+2+8 clks; pressedkey=6.
//     Release -> readKey falls 10 clks after release.
//  3. Press r3c2 with 3 bounces of 3 clks each, then stable -> exactly one readKey rise; pressedkey=10.
//  4. Hold r0c3 and r2c0 together -> pressedkey=12 (row 0 scanned first).
//     Release r0c3 while r2c0 held -> readKey falls, then rises again with pressedkey=7.
//  5. Press 5, 4-clk glitch during hold, release -> readKey stays 1 through the glitch; single pulse on readKey.
//  6. KEYPAD_TYPEMATIC_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10: hold 0 for 60 clks after readKey=1
//     -> 2-clk drops at +20, +30, +40, +50; pressedkey=0 throughout.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared key codes, scanner state encoding and the row/column to
//             calculator-code map for the 4x4 keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

  localparam logic [3:0] KEY_EQUAL = 4'd10;
  localparam logic [3:0] KEY_AC    = 4'd11;
  localparam logic [3:0] KEY_PLUS  = 4'd12;
  localparam logic [3:0] KEY_MINUS = 4'd13;
  localparam logic [3:0] KEY_MULT  = 4'd14;
  localparam logic [3:0] KEY_DIV   = 4'd15;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  // Physical key position -> calculator code.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_PLUS;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_MINUS;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_MULT;
      4'hC: code = KEY_AC;
      4'hD: code = 4'd0;
      4'hE: code = KEY_EQUAL;
      4'hF: code = KEY_DIV;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_sync2
//  Purpose  : 4-bit two-flop synchronizer for the asynchronous column lines.
//             Resets to all-ones (no key pressed).
//  Revision : 1.0  initial release
// ============================================================================
module keypad_sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two register stages to settle metastability on the raw column inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 4'b1111;
      r_sync <= 4'b1111;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Scans a 4x4 active-low matrix keypad, debounces one key at a
//             time and presents readKey / pressedkey to the calculator FSM.
//  Options  : KEYPAD_TYPEMATIC_EN - auto-repeat (2-clock readKey drop) while a
//             key is held.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE_CNT  = 500000
`ifdef KEYPAD_TYPEMATIC_EN
  ,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       readKey,
  output logic [3:0] pressedkey
);

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] c_DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] c_CNT_MAX  = CW'(DEBOUNCE_CNT);
  // The clock that first sees the new column level counts as stable clock 1,
  // so the counting state only needs DEBOUNCE_CNT-1 further clocks.
  localparam logic [CW-1:0] c_CNT_EXIT = CW'((DEBOUNCE_CNT >= 2) ? DEBOUNCE_CNT - 2 : 0);

`ifdef KEYPAD_TYPEMATIC_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] c_REP_MAX          = RW'(REP_MAX);
  localparam logic [RW-1:0] c_REP_DELAY_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] c_REP_PERIOD_LAST  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rep;
  logic          r_first;
  logic [1:0]    r_drop;
`endif

  logic [3:0]    w_cols_s;
  kp_state_t     r_state;
  logic [DW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_row;
  logic [1:0]    r_col;
  logic [3:0]    r_rows;
  logic          r_read;
  logic [3:0]    r_code;

  logic          w_any_low;
  logic [1:0]    w_low_col;
  logic          w_col_high;

  keypad_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (cols),
    .o_q   (w_cols_s)
  );

  // Lowest-index low column wins when several keys in one row are down.
  always_comb begin
    w_low_col = 2'd3;
    if (!w_cols_s[0])      w_low_col = 2'd0;
    else if (!w_cols_s[1]) w_low_col = 2'd1;
    else if (!w_cols_s[2]) w_low_col = 2'd2;
  end

  assign w_any_low  = ~&w_cols_s;
  assign w_col_high = w_cols_s[r_col];

  // Scan / debounce / hold / release state machine with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SCAN;
      r_div   <= '0;
      r_cnt   <= '0;
      r_row   <= 2'd0;
      r_col   <= 2'd0;
      r_rows  <= 4'b1110;
      r_read  <= 1'b0;
      r_code  <= 4'd0;
`ifdef KEYPAD_TYPEMATIC_EN
      r_rep   <= '0;
      r_first <= 1'b1;
      r_drop  <= 2'd0;
`endif
    end else begin
`ifdef KEYPAD_TYPEMATIC_EN
      // Restore readKey after a 2-clock repeat drop; state actions below win.
      if (r_drop != 2'd0) begin
        r_drop <= r_drop - 2'd1;
        if (r_drop == 2'd1) r_read <= 1'b1;
      end
`endif
      case (r_state)
        SCAN: begin
          if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            if (w_any_low) begin
              r_col   <= w_low_col;
              r_cnt   <= '0;
              r_state <= DEBOUNCE;
            end else begin
              r_row  <= r_row + 2'd1;
              r_rows <= {r_rows[2:0], r_rows[3]};
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (w_col_high) begin
            r_cnt   <= '0;
            r_div   <= '0;
            r_row   <= r_row + 2'd1;
            r_rows  <= {r_rows[2:0], r_rows[3]};
            r_state <= SCAN;
          end else if (r_cnt >= c_CNT_EXIT) begin
            r_code  <= keymap(r_row, r_col);
            r_read  <= 1'b1;
            r_cnt   <= '0;
            r_state <= PRESSED;
          end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (w_col_high) begin
            r_cnt   <= '0;
            r_state <= RELEASE;
`ifdef KEYPAD_TYPEMATIC_EN
            r_rep   <= '0;
            r_first <= 1'b1;
`endif
          end
`ifdef KEYPAD_TYPEMATIC_EN
          else if (r_rep >= (r_first ? c_REP_DELAY_LAST : c_REP_PERIOD_LAST)) begin
            r_read  <= 1'b0;
            r_drop  <= 2'd2;
            r_rep   <= '0;
            r_first <= 1'b0;
          end else if (r_rep != c_REP_MAX) begin
            r_rep <= r_rep + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (!w_col_high) begin
            r_cnt   <= '0;
            r_state <= PRESSED;
          end else if (r_cnt >= c_CNT_EXIT) begin
            r_read  <= 1'b0;
            r_cnt   <= '0;
            r_div   <= '0;
            r_row   <= 2'd0;
            r_rows  <= 4'b1110;
            r_state <= SCAN;
`ifdef KEYPAD_TYPEMATIC_EN
            r_drop  <= 2'd0;
`endif
          end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign rows       = r_rows;
  assign readKey    = r_read;
  assign pressedkey = r_code;

endmodule
`default_nettype wire
